// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, stream framing and default sizes.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        GAP,
        RUN,
        ERR
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_ADDR_W = 9;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word packer: every BYTES_PER_WORD accepted bytes yield one word,
// presented on word_o with a single-cycle word_valid_o on the cycle after the last byte.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam int SR_W  = 8 * (BYTES_PER_WORD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [SR_W-1:0]  sr_q;
    logic [31:0]      word_q;
    logic             valid_q;

    // The shift register keeps filling while word_q is still being presented downstream.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (clear_i) begin
                cnt_q <= '0;
                sr_q  <= '0;
            end else if (byte_valid_i) begin
                if (cnt_q == CNT_W'(BYTES_PER_WORD - 1)) begin
                    word_q  <= {sr_q, byte_i};
                    valid_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sr_q  <= {sr_q[SR_W-9:0], byte_i};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: parses a length header, writes packed words into instruction RAM,
// then raises working. Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int MAX_WORDS = 512
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [31:0]       wdata,
    output logic              working,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_e AFTER_DATA = CHK;
`else
    localparam state_e AFTER_DATA = GAP;
`endif

    state_e          state_q, state_d;
    logic [7:0]      len_hi_q;
    logic [ADDR_W:0] last_idx_q;
    logic [ADDR_W:0] idx_q;
    logic [15:0]     len_rx;
    logic            xfer;
    logic            start_ok;
    logic            last_wr;
    logic            len_bad;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]      chk_q;
`endif

    assign xfer     = in_valid && in_ready;
    assign start_ok = start && !busy;
    assign last_wr  = wr && (idx_q == last_idx_q);
    assign len_rx   = {len_hi_q, in_data};
    assign len_bad  = (len_rx == 16'd0) || (len_rx > 16'(MAX_WORDS));

    // Nothing more is taken in DATA once the final word is being written.
    assign in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == CHK)
                   || ((state_q == DATA) && !last_wr);
    assign busy     = state_q inside {LEN_HI, LEN_LO, DATA, CHK, GAP};
    assign working  = (state_q == RUN);
    assign error    = (state_q == ERR);
    assign addr         = wr ? idx_q[ADDR_W-1:0] : '0;
    assign words_loaded = idx_q + (ADDR_W+1)'(wr);

    word_assembler u_asm (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      (start_ok),
        .byte_valid_i (xfer && (state_q == DATA)),
        .byte_i       (in_data),
        .word_valid_o (wr),
        .word_o       (wdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN, ERR: if (start_ok) state_d = LEN_HI;
            LEN_HI:         if (xfer) state_d = LEN_LO;
            LEN_LO:         if (xfer) state_d = len_bad ? ERR : DATA;
            DATA:           if (last_wr) state_d = AFTER_DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHK:            if (xfer) state_d = (in_data == chk_q) ? GAP : ERR;
`endif
            GAP:            state_d = RUN;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_hi_q   <= '0;
            last_idx_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == LEN_HI) && xfer) begin
                len_hi_q <= in_data;
            end
            if ((state_q == LEN_LO) && xfer) begin
                last_idx_q <= (ADDR_W+1)'(len_rx - 16'd1);
            end
            if (start_ok) begin
                idx_q <= '0;
            end else if (wr) begin
                idx_q <= idx_q + (ADDR_W+1)'(1);
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chk_q <= '0;
        end else if (start_ok) begin
            chk_q <= '0;
        end else if ((state_q == DATA) && xfer) begin
            chk_q <= chk_q ^ in_data;
        end
    end
`endif

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream feeder for the processor.
- Receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit instruction words.
- Writes each word into the processor's instruction RAM through the processor's existing addr/wr/wdata load port.
- Raises working once the whole program is in RAM, which hands RAM addressing to the processor's PC.

Parameters:
- ADDR_W, 9: RAM address width; matches the processor's addr port.
- MAX_WORDS, 512: largest legal program length; must be at most 2^ADDR_W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a new load.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader accepts in_data this cycle.
- addr  out  ADDR_W  RAM write address; drives the processor's addr.
- wr  out  1  RAM write strobe; drives the processor's wr.
- wdata  out  32  RAM write data; drives the processor's wdata.
- working  out  1  run enable; drives the processor's working.
- busy  out  1  a load is in progress.
- error  out  1  the last load was rejected; sticky until the next start.
- words_loaded  out  ADDR_W+1  count of words written by the current or last load.

Behaviour:
- Reset (asynchronous, active-low): state IDLE.
  - addr=0, wr=0, wdata=0, working=0, busy=0, error=0, words_loaded=0, in_ready=0.
- A byte transfer happens on any rising edge where in_valid=1 and in_ready=1.
- Stream format:
  - 2-byte length header, big-endian: LEN[15:8], then LEN[7:0].
  - Then LEN words, 4 bytes each, most significant byte first. So bytes 10,F0,00,80 form 0x10F00080.
- States:
  - IDLE: in_ready=0. start -> LEN_HI; working cleared, error cleared, words_loaded=0.
  - LEN_HI: in_ready=1. Transfer captures LEN[15:8] -> LEN_LO.
  - LEN_LO: in_ready=1. Transfer captures LEN[7:0]. If LEN==0 or LEN>MAX_WORDS -> ERR; otherwise -> DATA.
  - DATA: in_ready=1.
    - Each 4th byte completes a word. On the next cycle wr=1 for exactly one cycle, with addr = word index (first word at 0) and wdata = the assembled word.
    - words_loaded increments in the same cycle as the wr pulse.
    - Bytes continue to be accepted during the wr cycle; the assembly shift register is separate from the wdata register.
    - After the wr pulse for word LEN-1 -> GAP.
  - GAP: one cycle. wr=0, addr=0, in_ready=0 -> RUN.
  - RUN: working=1, busy=0, in_ready=0. start -> LEN_HI; working drops on that same edge.
  - ERR: error=1, working=0, in_ready=0. start -> LEN_HI.
- busy=1 in LEN_HI, LEN_LO, DATA and GAP.
- start is ignored while busy.
- wr and working are never high in the same cycle. addr is 0 whenever wr=0, so the processor's PC-versus-addr mux sees a clean handover.
- Timing:
  - Latency from the 4th byte transfer to the wr pulse: 1 cycle.
  - From the last wr pulse to working=1: 2 cycles.
- in_valid with in_ready=0 is not consumed; the byte is held by the source.
- reset_n asserted mid-load: immediate return to IDLE. RAM contents are left as written; words_loaded is cleared.
- start and reset_n asserted together: reset wins.
- addr wraps: not reachable, because LEN is bounded by MAX_WORDS.

Optional Feature:
- Macro PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the last data byte: the XOR of all data bytes (header excluded).
  - State CHK accepts this byte after the final word's wr pulse.
  - Match -> GAP -> RUN.
  - Mismatch -> ERR. working stays 0; the RAM contents are not trusted.
- Not defined: no trailing byte. DATA goes straight to GAP.

Decomposition:
- Shared package program_loader_pkg holds:
  - the state enum: IDLE, LEN_HI, LEN_LO, DATA, CHK, GAP, RUN, ERR;
  - the header byte count, 2;
  - the bytes-per-word constant, 4;
  - the default ADDR_W.
- One sub-module, word_assembler:
  - 8-to-32 big-endian shift packer with a 2-bit byte counter;
  - emits word_valid for one cycle together with the word;
  - clearable on start.
- The top level holds the FSM, address counter, length register and optional checksum.

Test Plan:
- Load LEN=12 using the 12 words 10F00080..10F70087, 20010000, 21230000, 22450000, 23670000, with in_valid held high -> 12 single-cycle wr pulses at addr 0..11 with exactly these wdata values; working=1 two cycles after the last pulse; words_loaded=12.
- Same stream with in_valid randomly deasserted -> identical write sequence and data; no byte lost or duplicated.
- Header 00 00, then header 02 01 (513) -> error=1, no wr pulses, working=0; a following start with a valid LEN=1 stream clears error and loads the word.
- reset_n pulled low after the 6th data byte -> all outputs return to reset values asynchronously; the next start plus a full stream loads correctly from addr 0.
- start pulsed during DATA is ignored; start in RUN drops working on the same edge and reloads from addr 0.
- With PROGRAM_LOADER_CHECKSUM_EN: LEN=1, word 10F00080, checksum byte 0x60 -> RUN; checksum byte 0x61 -> ERR with working=0.
